// File: rtl/ir_grid_scanner.sv
// 4x4 IR beam grid scanner: drives one row at a time, synchronizes column returns,
// and debounces each cell over whole scan frames into a registered occupancy vector.
module ir_grid_scanner #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic [3:0]  ir_col,
    output logic [3:0]  ir_row_sel,
    output logic [15:0] ir_in,
    output logic        frame_done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DB_MAX     = 4'(DEBOUNCE_FRAMES - 1);

    logic [3:0]  r_sync1;
    logic [3:0]  r_col_s;
    logic [1:0]  r_state;
    logic [1:0]  r_row;
    logic [7:0]  r_settle;
    logic [3:0]  r_row_sel;
    logic [15:0] r_ir;
    logic [3:0]  r_cnt [16];
    logic        r_frame_done;

    logic [1:0]  w_state_nxt;
    logic [1:0]  w_row_nxt;
    logic [7:0]  w_settle_nxt;
    logic [3:0]  w_row_sel_nxt;
    logic        w_frame_done_nxt;
    logic        w_sample_en;
    logic [15:0] w_ir_nxt;
    logic [3:0]  w_cnt_nxt [16];

    // One debounce step for a cell: returns {new_state, new_count}.
    function automatic logic [4:0] debounce_step(input logic state,
                                                 input logic [3:0] cnt,
                                                 input logic sample);
        logic [4:0] res;
        if (sample == state) begin
            res = {state, 4'd0};
        end else if (cnt == DB_MAX) begin
            res = {~state, 4'd0};
        end else begin
            res = {state, cnt + 4'd1};
        end
        return res;
    endfunction

    // Row scan sequencing: settle each driven row, then sample it for one cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_settle_nxt     = r_settle;
        w_row_sel_nxt    = r_row_sel;
        w_frame_done_nxt = 1'b0;
        w_sample_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt   = ST_SETTLE;
                    w_row_nxt     = 2'd0;
                    w_row_sel_nxt = 4'b0001;
                    w_settle_nxt  = 8'd0;
                end else begin
                    w_row_sel_nxt = 4'b0000;
                end
            end
            ST_SETTLE: begin
                if (r_settle == SETTLE_MAX) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_settle_nxt = r_settle + 8'd1;
                end
            end
            ST_SAMPLE: begin
                w_sample_en = 1'b1;
                if (r_row != 2'd3) begin
                    w_row_nxt     = r_row + 2'd1;
                    w_row_sel_nxt = {r_row_sel[2:0], 1'b0};
                    w_settle_nxt  = 8'd0;
                    w_state_nxt   = ST_SETTLE;
                end else begin
                    // enable is only re-examined here, so a frame always completes
                    w_frame_done_nxt = 1'b1;
                    w_row_nxt        = 2'd0;
                    w_settle_nxt     = 8'd0;
                    if (enable) begin
                        w_state_nxt   = ST_SETTLE;
                        w_row_sel_nxt = 4'b0001;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_row_sel_nxt = 4'b0000;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_row_nxt     = 2'd0;
                w_settle_nxt  = 8'd0;
                w_row_sel_nxt = 4'b0000;
            end
        endcase
    end

    // Per-cell debounce of the currently sampled row.
    always_comb begin
        w_ir_nxt = r_ir;
        for (int i = 0; i < 16; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_sample_en && (2'(i / 4) == r_row)) begin
                {w_ir_nxt[4'(i)], w_cnt_nxt[i]} =
                    debounce_step(r_ir[4'(i)], r_cnt[i], r_col_s[2'(i % 4)]);
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // State registers; clear wipes cell state and discards a coincident sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= 4'd0;
            r_col_s      <= 4'd0;
            r_state      <= ST_IDLE;
            r_row        <= 2'd0;
            r_settle     <= 8'd0;
            r_row_sel    <= 4'd0;
            r_ir         <= 16'd0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            r_sync1      <= ir_col;
            r_col_s      <= r_sync1;
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_settle     <= w_settle_nxt;
            r_row_sel    <= w_row_sel_nxt;
            r_frame_done <= w_frame_done_nxt;
            if (clear) begin
                r_ir <= 16'd0;
                for (int i = 0; i < 16; i++) begin
                    r_cnt[i] <= 4'd0;
                end
            end else begin
                r_ir <= w_ir_nxt;
                for (int i = 0; i < 16; i++) begin
                    r_cnt[i] <= w_cnt_nxt[i];
                end
            end
        end
    end

    assign ir_row_sel = r_row_sel;
    assign ir_in      = r_ir;
    assign frame_done = r_frame_done;

endmodule

// File: doc/ir_grid_scanner.md
# ir_grid_scanner

Front end for the 4x4 spell-tracing grid. It scans a 4x4 matrix of IR beam sensors one row at a time and synchronizes the raw column returns. Each cell is debounced over whole scan frames. The result is a clean 16-bit occupancy vector on `ir_in`, which feeds the grid renderer/trace logic. Bit index is `row*4 + col`, matching box numbering: box 0 is top-left and box 15 is bottom-right.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4. Cycles a row is driven before its columns are sampled. Legal range 3..255; the minimum covers the 2-flop synchronizer.
- `DEBOUNCE_FRAMES`, default 3. Consecutive frames a cell must disagree with its current state before the state flips. Legal range 1..15.

Ports:
- `clk`, input, 1 bit. Single clock; all logic is on the rising edge.
- `reset`, input, 1 bit. Synchronous, active-high.
- `enable`, input, 1 bit. Scanning permitted.
- `clear`, input, 1 bit. Synchronous clear of `ir_in` and all debounce counters.
- `ir_col`, input, 4 bits. Raw asynchronous column returns. 1 = beam broken / hand present. Bit n = column n.
- `ir_row_sel`, output, 4 bits. One-hot row drive. Bit r = row r. All zeros when idle.
- `ir_in`, output, 16 bits. Debounced cell state, registered.
- `frame_done`, output, 1 bit. One-cycle pulse when a full 4-row frame has been applied to `ir_in`.

## Operation
- **Reset values:** `ir_row_sel`=0, `ir_in`=0, `frame_done`=0, row counter=0, settle counter=0, all debounce counters=0, synchronizer flops=0, state=IDLE.
- **Synchronizer:** `ir_col` passes through two flops. Only the synchronized value (`col_s`) is ever used.
- **FSM states:** IDLE, SETTLE, SAMPLE.
  - IDLE: `ir_row_sel`=0. If `enable`=1, go to SETTLE with row=0, `ir_row_sel`=0001, settle count=0.
  - SETTLE: settle count increments each cycle. When the count equals `SETTLE_CYCLES-1`, go to SAMPLE.
  - SAMPLE: lasts one cycle with `ir_row_sel` unchanged. `col_s[c]` updates cell `row*4+c`. Then:
    - If row<3: row+1, `ir_row_sel` shifts left, go to SETTLE with count=0.
    - If row==3: pulse `frame_done` on the next cycle. Then, if `enable`=1, go to SETTLE row 0; otherwise go to IDLE.
- **Enable:** `enable` is examined only in IDLE and at the row-3 SAMPLE. Deasserting it mid-frame lets the frame complete.
- **Per-cell debounce (counter width 4):**
  - Sample equals the state bit: counter clears to 0.
  - Sample differs and counter==`DEBOUNCE_FRAMES-1`: the state bit flips and the counter clears.
  - Sample differs otherwise: counter increments.
  - Set and release use identical rules.
- **Clear:** `clear`=1 zeroes `ir_in` and all counters in the same cycle. It has priority over a coincident SAMPLE update, and that sample is discarded. `clear` does not affect the FSM, row, or `ir_row_sel`.
- **Priority:** `reset` > `clear` > SAMPLE update.
- `reset` mid-frame aborts immediately. The first cycle after release is IDLE.

## Timing
- One row takes `SETTLE_CYCLES+1` cycles. The frame period is `4*(SETTLE_CYCLES+1)` cycles: 20 at default.
- An `ir_col` change visible at cycle t is usable if t ≤ SAMPLE cycle − 2, because of synchronizer latency.
- `ir_in` updates on the edge ending SAMPLE, so it is visible one cycle after SAMPLE.
- For the row-3 SAMPLE, `frame_done` is asserted in the same cycle the updated `ir_in` becomes visible.
- A steady cell change appears in `ir_in` after exactly `DEBOUNCE_FRAMES` frames, at that cell's SAMPLE in the last of those frames.
- From `enable` rising in IDLE: `ir_row_sel`=0001 after 1 cycle. The first `frame_done` follows 20 cycles later at default.

## Test plan
Bench model: `ir_col` = f(`ir_row_sel`), combinational.
- **Reset mid-scan:** with row 2 driven, assert `reset` for 2 cycles -> `ir_row_sel`=0, `ir_in`=0, `frame_done`=0. With `enable`=1 after release: IDLE for 1 cycle, then `ir_row_sel`=0001.
- **Single cell set:** return `ir_col`=0010 only while `ir_row_sel`=0100 -> `ir_in` stays 0 through frames 1–2, becomes 16'h0200 after frame 3's row-2 SAMPLE, and `frame_done` pulses every 20 cycles.
- **Glitch rejection:** cell 5 present for 2 frames, then absent -> `ir_in` stays 16'h0000. Cell 5 present again then takes a full 3 frames to set.
- **Release:** all cells present for 3 frames -> `ir_in`=16'hFFFF. All absent afterwards -> `ir_in`=16'h0000 after exactly 3 more frames.
- **Clear collision:** assert `clear` in the SAMPLE cycle that would set cell 0 -> `ir_in`=0 and counters reset. Cell 0 sets again only after 3 further frames.
- **Enable drop:** drop `enable` during row 1 -> rows 2–3 still scan and `frame_done` pulses. Then `ir_row_sel`=0000 and no further `frame_done` until `enable` returns.
